// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
//
// One M-extension operation at a time. Multiplies run a shift-add on operand
// magnitudes (MUL_BITS_PER_CYCLE multiplier bits per cycle); divides run a
// restoring divide (one quotient bit per cycle). Divide-by-zero and signed
// overflow finish through a one-cycle fast path. The pipeline is held with
// stall_o while an operation is accepted or in flight, and the result comes
// back in a single done_o beat.
//
// Build option: define EX_MULDIV_DIV_EN to include the divider datapath.
// Without it, ops 4-7 complete through the fast path with a zero result.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start_i   request, sampled only in IDLE
//   op_i      funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU)
//   a_i, b_i  forwarded rs1 / rs2 values
//   rd_i      destination register
//   flush_i   synchronous abort, wins over start_i
//   stall_o   combinational pipeline hold
//   busy_o    registered, high in CALC
//   done_o    registered one-cycle completion pulse
//   result_o  result, valid with done_o, held until the next completion
//   rd_o      destination register, valid with done_o

module ex_muldiv #(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // CALC  | iterating, counter counts down to 1
    // DONE  | done_o high for one cycle, result_o / rd_o valid
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    localparam int K  = MUL_BITS_PER_CYCLE;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] N_MUL = CW'(WIDTH / K);
    localparam logic [CW-1:0] N_DIV = CW'(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [4:0]         rd_q;
    logic               neg_q;
    // Multiplicand for multiplies, divisor for divides.
    logic [WIDTH-1:0]   opnd_q;
    // Multiply: {partial product high, remaining multiplier / product low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q;

    logic               a_signed, b_signed, a_neg, b_neg, is_div, res_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;

    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed && a_i[WIDTH-1];
        b_neg    = b_signed && b_i[WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        is_div   = op_i[2];
        // Remainder follows the dividend's sign; everything else is sign(a)^sign(b).
        if (op_i == OP_REM)
            res_neg = a_neg;
        else if (op_i == OP_REMU)
            res_neg = 1'b0;
        else
            res_neg = a_neg ^ b_neg;
        fast     = 1'b0;
        fast_res = '0;
`ifdef EX_MULDIV_DIV_EN
        if (is_div) begin
            if (b_i == '0) begin
                fast     = 1'b1;
                fast_res = op_i[1] ? a_i : '1;
            end else if (!op_i[0] && (a_i == INT_MIN) && (b_i == '1)) begin
                fast     = 1'b1;
                fast_res = op_i[1] ? '0 : a_i;
            end
        end
`else
        fast = is_div;
`endif
    end

    logic [K-1:0]       mul_digit;
    logic [WIDTH+K-1:0] mul_sum;
    logic [2*WIDTH-1:0] mul_nxt, prod, acc_nxt;
    logic [WIDTH-1:0]   calc_res;
`ifdef EX_MULDIV_DIV_EN
    logic [WIDTH:0]     rem_sh, div_diff;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   div_sel;
`endif

    always_comb begin
        mul_digit = acc_q[K-1:0];
        mul_sum   = {{K{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} +
                    ((WIDTH+K)'(opnd_q) * (WIDTH+K)'(mul_digit));
        mul_nxt   = {mul_sum, acc_q[WIDTH-1:K]};
        prod      = neg_q ? -mul_nxt : mul_nxt;
        acc_nxt   = mul_nxt;
        calc_res  = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef EX_MULDIV_DIV_EN
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold the
        // shifted value and the difference's top bit is its sign.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        if (div_diff[WIDTH])
            div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        div_sel = op_q[1] ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
        if (op_q[2]) begin
            acc_nxt  = div_nxt;
            calc_res = neg_q ? -div_sel : div_sel;
        end
`endif
    end

    assign stall_o = ((state == ST_IDLE) && start_i && !flush_i) || (state == ST_CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            if (flush_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            op_q  <= op_i;
                            rd_q  <= rd_i;
                            neg_q <= res_neg;
                            if (fast) begin
                                state    <= ST_DONE;
                                done_o   <= 1'b1;
                                result_o <= fast_res;
                                rd_o     <= rd_i;
                                cnt      <= '0;
                            end else begin
                                state  <= ST_CALC;
                                busy_o <= 1'b1;
                                cnt    <= is_div ? N_DIV : N_MUL;
                                opnd_q <= is_div ? b_mag : a_mag;
                                acc_q  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                            end
                        end
                    end
                    ST_CALC: begin
                        acc_q <= acc_nxt;
                        cnt   <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state    <= ST_DONE;
                            done_o   <= 1'b1;
                            result_o <= calc_res;
                            rd_o     <= rd_q;
                        end else begin
                            busy_o <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: two instances (1 and 4 multiplier bits per cycle)
// share one stimulus stream; a reference model pushes expected result, rd and
// completion cycle into per-instance queues that monitors pop on done_o.

module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    logic        stall1, busy1, done1, stall4, busy4, done4;
    logic [31:0] res1, res4;
    logic [4:0]  rdo1, rdo4;

    ex_muldiv #(.WIDTH(32), .MUL_BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .rd_i(rd), .flush_i(flush), .stall_o(stall1), .busy_o(busy1),
        .done_o(done1), .result_o(res1), .rd_o(rdo1));

    ex_muldiv #(.WIDTH(32), .MUL_BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .rd_i(rd), .flush_i(flush), .stall_o(stall4), .busy_o(busy4),
        .done_o(done4), .result_o(res4), .rd_o(rdo4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] pu;
        longint      ps;
        logic [63:0] pb;
        case (f)
            3'd0: begin pu = {32'b0, x} * {32'b0, y}; return pu[31:0]; end
            3'd1: begin ps = longint'($signed(x)) * longint'($signed(y)); pb = ps; return pb[63:32]; end
            3'd2: begin ps = longint'($signed(x)) * longint'({32'b0, y}); pb = ps; return pb[63:32]; end
            3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            default: begin
`ifdef EX_MULDIV_DIV_EN
                if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
                if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'd0 : x;
                case (f)
                    3'd4:    return $signed(x) / $signed(y);
                    3'd5:    return x / y;
                    3'd6:    return $signed(x) % $signed(y);
                    default: return x % y;
                endcase
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    // Cycle (after the accept edge) in which done_o is expected.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int k);
        if (!f[2]) return 32 / k + 1;
`ifdef EX_MULDIV_DIV_EN
        if (y == 32'd0) return 1;
        if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 1;
`endif
    endfunction

    // Called at a negedge; that cycle is cycle 0 of the operation.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input bit wait_done, input bit expect1,
                         output int c0);
        exp_t e;
        int   n, lat1, lat4;
        op = f; a = x; b = y; rd = r; start = 1'b1;
        c0 = cyc;
        lat1 = ref_lat(f, x, y, 1);
        lat4 = ref_lat(f, x, y, 4);
        e.res = ref_res(f, x, y);
        e.rd  = r;
        if (expect1) begin e.due = c0 + lat1; q1.push_back(e); end
        e.due = c0 + lat4; q4.push_back(e);
        #1 chk("stall_at_accept", stall1, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        if (wait_done) begin
            n = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (stall1) n++;
                else break;
            end
            chk("stall_length", n, lat1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_done: got result %0h, expected no completion", res1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_result", res1, e1.res);
                chk("dut1_rd", rdo1, e1.rd);
                chk("dut1_done_cycle", cyc, e1.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4_unexpected_done: got result %0h, expected no completion", res4);
            end else begin
                e4 = q4.pop_front();
                chk("dut4_result", res4, e4.res);
                chk("dut4_rd", rdo4, e4.rd);
                chk("dut4_done_cycle", cyc, e4.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [31:0] x, y;
        int m;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd = '0;
        #12;
        chk("reset_busy", busy1, 1'b0);
        chk("reset_done", done1, 1'b0);
        chk("reset_result", res1, 32'd0);
        chk("reset_rd", rdo1, 5'd0);
        chk("reset_stall", stall1, 1'b0);
        @(negedge clk) rst = 1'b0;

        // Directed: multiplies, divides, fast paths.
        @(negedge clk) issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1, 1, c);
        @(negedge clk) issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 1, c);
        @(negedge clk) issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 1, c);
        @(negedge clk) issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1, 1, c);
        @(negedge clk) issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1, 1, c);
        @(negedge clk) issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1, 1, c);
        @(negedge clk) issue(3'd5, 32'd100, 32'd7, 5'd9, 1, 1, c);
        @(negedge clk) issue(3'd7, 32'd100, 32'd7, 5'd10, 1, 1, c);
        @(negedge clk) issue(3'd5, 32'd5, 32'd0, 5'd11, 1, 1, c);
        @(negedge clk) issue(3'd6, 32'd5, 32'd0, 5'd12, 1, 1, c);
        @(negedge clk) issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 1, c);
        @(negedge clk) issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 1, c);
        @(negedge clk) issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd15, 1, 1, c);

        // Flush in cycle 10 of a MUL; the x4 instance has already completed.
        @(negedge clk) issue(3'd0, 32'd9, 32'd9, 5'd16, 0, 0, c);
        for (int i = 0; i < 20 && cyc < c + 10; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_low", busy1, 1'b0);
        chk("flush_stall_low", stall1, 1'b0);
        issue(3'd0, 32'd3, 32'd4, 5'd17, 1, 1, c);

        // start_i together with flush_i is not accepted.
        @(negedge clk);
        op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1; flush = 1'b1;
        #1 chk("start_flush_stall", stall1, 1'b0);
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("start_flush_busy", busy1, 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk) issue(3'd4, 32'd100, 32'd7, 5'd18, 0, 1, c);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy1, 1'b0);
        chk("async_rst_done", done1, 1'b0);
        chk("async_rst_result", res1, 32'd0);
        chk("async_rst_rd", rdo1, 5'd0);
        q1.delete();
        q4.delete();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", busy1, 1'b0);
        chk("post_rst_idle_stall", stall1, 1'b0);

        // Randomized operations, biased towards the corner cases.
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 9);
            x = $urandom;
            y = $urandom;
            if (m == 0) y = 32'd0;
            else if (m == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (m == 2) begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
            else if (m == 3) y = 32'hFFFF_FFFF;
            @(negedge clk) issue(3'($urandom_range(0, 7)), x, y, 5'($urandom_range(0, 31)), 1, 1, c);
        end

        repeat (5) @(negedge clk);
        chk("dut1_queue_drained", q1.size(), 0);
        chk("dut4_queue_drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
